// File: rtl/mul_by_d_csd.sv
// Complex signed-digit multiplier: (x + jy) * (d_x + j*d_y) with d_x, d_y in {-1,0,+1}.
// Operands go through CSD form, products are summed mod 2^W and returned registered in binary and NAF.
module mul_by_d_csd #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [1:0]     d_x,
    input  logic [1:0]     d_y,
    input  logic [W-1:0]   x_in,
    input  logic [W-1:0]   y_in,
    output logic [W-1:0]   x_out,
    output logic [W-1:0]   y_out,
    output logic [2*W-1:0] x_out_csd,
    output logic [2*W-1:0] y_out_csd
);

    // NAF via the 3n trick: xh = n>>1 (arithmetic), x3 = n + xh, digit i nonzero where xh^x3 is set.
    // Truncating to W bits is safe because every bit only depends on lower-order bits.
    function automatic logic [2*W-1:0] bin2csd(input logic [W-1:0] v);
        logic [W-1:0]   xh;
        logic [W-1:0]   x3;
        logic [W-1:0]   c;
        logic [W-1:0]   np;
        logic [W-1:0]   nm;
        logic [2*W-1:0] r;
        xh = {v[W-1], v[W-1:1]};
        x3 = v + xh;
        c  = xh ^ x3;
        np = x3 & c;
        nm = xh & c;
        r  = '0;
        for (int i = 0; i < W; i++) begin
            if (nm[i])      r[2*i +: 2] = 2'b11;
            else if (np[i]) r[2*i +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] csd2bin(input logic [2*W-1:0] c);
        logic [W-1:0] p;
        logic [W-1:0] m;
        p = '0;
        m = '0;
        for (int i = 0; i < W; i++) begin
            p[i] = (c[2*i +: 2] == 2'b01);
            m[i] = (c[2*i +: 2] == 2'b11);
        end
        return p - m;
    endfunction

    function automatic logic [2*W-1:0] mul_d(input logic [2*W-1:0] c, input logic [1:0] d);
        logic [2*W-1:0] r;
        r = '0;
        case (d)
            2'b01: r = c;
            2'b11: begin
                for (int i = 0; i < W; i++) begin
                    r[2*i+1] = c[2*i+1] ^ c[2*i];
                    r[2*i]   = c[2*i];
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [2*W-1:0] x_csd;
    logic [2*W-1:0] y_csd;
    logic [1:0]     neg_d_y;
    logic [W-1:0]   x_sum;
    logic [W-1:0]   y_sum;

    logic [W-1:0]   x_d, x_q;
    logic [W-1:0]   y_d, y_q;
    logic [2*W-1:0] x_csd_d, x_csd_q;
    logic [2*W-1:0] y_csd_d, y_csd_q;

    always_comb begin
        x_csd   = bin2csd(x_in);
        y_csd   = bin2csd(y_in);
        // -d_y: flip the sign of a nonzero code; the reserved code stays zero-valued
        neg_d_y = {d_y[1] ^ d_y[0], d_y[0]};
        x_sum   = csd2bin(mul_d(x_csd, d_x)) + csd2bin(mul_d(y_csd, neg_d_y));
        y_sum   = csd2bin(mul_d(y_csd, d_x)) + csd2bin(mul_d(x_csd, d_y));
        x_d     = x_sum;
        y_d     = y_sum;
        x_csd_d = bin2csd(x_sum);
        y_csd_d = bin2csd(y_sum);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            x_csd_q <= '0;
            y_csd_q <= '0;
        end else if (ena) begin
            x_q     <= x_d;
            y_q     <= y_d;
            x_csd_q <= x_csd_d;
            y_csd_q <= y_csd_d;
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign x_out_csd = x_csd_q;
    assign y_out_csd = y_csd_q;

endmodule

// File: tb/tb_mul_by_d_csd.sv
// Directed and exhaustive checks of mul_by_d_csd at W=4 against an integer model.
module tb_mul_by_d_csd;
  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           ena;
  logic [1:0]     d_x;
  logic [1:0]     d_y;
  logic [W-1:0]   x_in;
  logic [W-1:0]   y_in;
  logic [W-1:0]   x_out;
  logic [W-1:0]   y_out;
  logic [2*W-1:0] x_out_csd;
  logic [2*W-1:0] y_out_csd;

  int n_vec;
  int n_err;

  mul_by_d_csd #(.W(W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .d_x(d_x), .d_y(d_y),
    .x_in(x_in), .y_in(y_in), .x_out(x_out), .y_out(y_out),
    .x_out_csd(x_out_csd), .y_out_csd(y_out_csd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dval(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int csd_val(input logic [2*W-1:0] c);
    int s;
    s = 0;
    for (int i = 0; i < W; i++) s += dval(c[2*i +: 2]) * (1 << i);
    return s;
  endfunction

  function automatic bit naf_ok(input logic [2*W-1:0] c);
    for (int i = 0; i < W; i++) begin
      if (c[2*i +: 2] == 2'b10) return 1'b0;
      if (i > 0 && c[2*i] && c[2*i-2]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive(input logic [1:0] dx, input logic [1:0] dy,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    d_x = dx; d_y = dy; x_in = x; y_in = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ena = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(2'b01, 2'b01, 4'd5, 4'd3);
      n_vec++;
      if ({x_out, y_out, x_out_csd, y_out_csd} !== '0) begin
        n_err++;
        $display("FAIL reset_clear: got x=%0h y=%0h xc=%0h yc=%0h expected all 0",
                 x_out, y_out, x_out_csd, y_out_csd);
      end
    end
    rst = 1'b1; ena = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(2'b01, 2'b00, 4'd7, 4'd6);
      n_vec++;
      if ({x_out, y_out, x_out_csd, y_out_csd} !== '0) begin
        n_err++;
        $display("FAIL reset_hold: got x=%0h y=%0h xc=%0h yc=%0h expected all 0",
                 x_out, y_out, x_out_csd, y_out_csd);
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0]   dxs[7];
    logic [1:0]   dys[7];
    logic [W-1:0] xs[7];
    logic [W-1:0] ys[7];
    logic [W-1:0] ex[7];
    logic [W-1:0] ey[7];
    dxs = '{2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10};
    dys = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01};
    xs  = '{4'd3,  4'd3,  4'd3,  4'd7,  4'd5,  4'h8,  4'd3};
    ys  = '{4'hE,  4'hE,  4'hE,  4'd7,  4'hD,  4'd0,  4'hE};
    ex  = '{4'd3,  4'd2,  4'hE,  4'd0,  4'd0,  4'h8,  4'd2};
    ey  = '{4'hE,  4'd3,  4'hD,  4'd2,  4'd0,  4'd0,  4'd3};
    ena = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive(dxs[k], dys[k], xs[k], ys[k]);
      n_vec++;
      if (x_out !== ex[k]) begin
        n_err++;
        $display("FAIL basic_x[%0d]: got %0d expected %0d", k, x_out, ex[k]);
      end
      n_vec++;
      if (y_out !== ey[k]) begin
        n_err++;
        $display("FAIL basic_y[%0d]: got %0d expected %0d", k, y_out, ey[k]);
      end
    end
  endtask

  task automatic test_csd();
    ena = 1'b1;
    drive(2'b01, 2'b00, 4'd7, 4'd0);
    n_vec++;
    if (x_out_csd !== 8'b01_00_00_11) begin
      n_err++;
      $display("FAIL csd_seven: got %b expected 01000011", x_out_csd);
    end
    drive(2'b01, 2'b00, 4'h8, 4'd0);
    n_vec++;
    if (x_out_csd !== 8'b11_00_00_00) begin
      n_err++;
      $display("FAIL csd_minus8: got %b expected 11000000", x_out_csd);
    end
    drive(2'b11, 2'b11, 4'd7, 4'd7);
    n_vec++;
    if (x_out_csd !== 8'h00) begin
      n_err++;
      $display("FAIL csd_zero: got %b expected 00000000", x_out_csd);
    end
    n_vec++;
    if (y_out_csd !== 8'b00_00_01_00) begin
      n_err++;
      $display("FAIL csd_two: got %b expected 00000100", y_out_csd);
    end
  endtask

  task automatic test_hold();
    ena = 1'b1;
    drive(2'b01, 2'b00, 4'd6, 4'd5);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b01, 4'd1, 4'd2);
      n_vec++;
      if (x_out !== 4'd6 || y_out !== 4'd5 || x_out_csd !== 8'b01_00_11_00) begin
        n_err++;
        $display("FAIL hold: got x=%0d y=%0d xc=%b expected x=6 y=5 xc=01001100",
                 x_out, y_out, x_out_csd);
      end
    end
  endtask

  task automatic test_reset_midstream();
    ena = 1'b1;
    drive(2'b01, 2'b00, 4'd3, 4'd4);
    rst = 1'b0;
    drive(2'b01, 2'b00, 4'd5, 4'd6);
    n_vec++;
    if ({x_out, y_out, x_out_csd, y_out_csd} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got x=%0d y=%0d expected 0 0", x_out, y_out);
    end
    rst = 1'b1; ena = 1'b0;
    drive(2'b01, 2'b00, 4'd5, 4'd6);
    n_vec++;
    if ({x_out, y_out, x_out_csd, y_out_csd} !== '0) begin
      n_err++;
      $display("FAIL reset_discard: got x=%0d y=%0d expected 0 0", x_out, y_out);
    end
  endtask

  task automatic test_exhaustive();
    logic [1:0]   codes[4];
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic [W-1:0] vx;
    logic [W-1:0] vy;
    int           xi;
    int           yi;
    codes = '{2'b00, 2'b01, 2'b11, 2'b10};
    ena = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int xv = 0; xv < 16; xv++) begin
          for (int yv = 0; yv < 16; yv++) begin
            xi = (xv >= 8) ? xv - 16 : xv;
            yi = (yv >= 8) ? yv - 16 : yv;
            ex = W'(dval(codes[a]) * xi - dval(codes[b]) * yi);
            ey = W'(dval(codes[a]) * yi + dval(codes[b]) * xi);
            drive(codes[a], codes[b], W'(xv), W'(yv));
            vx = W'(csd_val(x_out_csd));
            vy = W'(csd_val(y_out_csd));
            n_vec++;
            if (x_out !== ex || y_out !== ey) begin
              n_err++;
              $display("FAIL sweep_bin d=%b,%b x=%0d y=%0d: got %0d,%0d expected %0d,%0d",
                       codes[a], codes[b], xi, yi, x_out, y_out, ex, ey);
            end
            n_vec++;
            if (vx !== ex || vy !== ey || !naf_ok(x_out_csd) || !naf_ok(y_out_csd)) begin
              n_err++;
              $display("FAIL sweep_csd d=%b,%b x=%0d y=%0d: got %b,%b expected NAF of %0d,%0d",
                       codes[a], codes[b], xi, yi, x_out_csd, y_out_csd, ex, ey);
            end
          end
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0; ena = 1'b0;
    d_x = 2'b00; d_y = 2'b00; x_in = '0; y_in = '0;
    test_reset();
    test_basic();
    test_csd();
    test_hold();
    test_reset_midstream();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
